// File: rtl/mul_sequencer.sv
// Multi-cycle controller for the 32x32 multiplier: captures operands, holds the multiplier
// inputs for MUL_LAT cycles, accumulates, then writes back one or two words plus N/Z flags.
module mul_sequencer #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        long_op,
    input  logic        acc,
    input  logic        signed_op,
    input  logic        setflags,
    input  logic [31:0] rm,
    input  logic [31:0] rs,
    input  logic [31:0] acc_lo,
    input  logic [31:0] acc_hi,
    input  logic [3:0]  rd_lo,
    input  logic [3:0]  rd_hi,
    input  logic        abort,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    output logic        mul_sign,
    input  logic [63:0] mul_out,
    output logic        busy,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        flag_we,
    output logic        flag_n,
    output logic        flag_z,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ADD,
        S_WB_LO,
        S_WB_HI
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

    state_t      state, state_d;
    logic [2:0]  cnt;
    logic [31:0] rm_q, rs_q, acc_lo_q, acc_hi_q;
    logic [3:0]  rd_lo_q, rd_hi_q;
    logic        long_q, acc_q, signed_q, setflags_q;
    logic [63:0] p_q, r_q;
    logic        final_wb;
    logic        capture;

    // A new request is also taken in the final writeback cycle so held START runs back-to-back.
    assign final_wb = (state == S_WB_LO && !long_q) || (state == S_WB_HI);
    assign capture  = start && !abort && (state == S_IDLE || final_wb);

    assign mul_ina  = rm_q;
    assign mul_inb  = rs_q;
    assign mul_sign = signed_q & long_q;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state;
        busy    = (state != S_IDLE);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        done    = 1'b0;
        flag_we = 1'b0;
        flag_n  = 1'b0;
        flag_z  = 1'b0;

        unique case (state)
            S_IDLE:  if (capture) state_d = S_MUL;
            S_MUL:   if (cnt == 3'd0) state_d = S_ADD;
            S_ADD:   state_d = S_WB_LO;
            S_WB_LO: begin
                wr_en   = 1'b1;
                wr_addr = rd_lo_q;
                wr_data = r_q[31:0];
                if (long_q)       state_d = S_WB_HI;
                else if (capture) state_d = S_MUL;
                else              state_d = S_IDLE;
            end
            S_WB_HI: begin
                wr_en   = 1'b1;
                wr_addr = rd_hi_q;
                wr_data = r_q[63:32];
                state_d = capture ? S_MUL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (final_wb && !abort) begin
            done    = 1'b1;
            flag_we = setflags_q;
            flag_n  = long_q ? r_q[63] : r_q[31];
            flag_z  = long_q ? (r_q == 64'd0) : (r_q[31:0] == 32'd0);
        end

        // Flush: strobes are suppressed this cycle; address/data are left as decoded.
        if (abort) begin
            state_d = S_IDLE;
            wr_en   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: the operand, product and result registers are reset too, because the multiplier
    // inputs are visible outputs and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rm_q       <= '0;
            rs_q       <= '0;
            acc_lo_q   <= '0;
            acc_hi_q   <= '0;
            rd_lo_q    <= '0;
            rd_hi_q    <= '0;
            long_q     <= 1'b0;
            acc_q      <= 1'b0;
            signed_q   <= 1'b0;
            setflags_q <= 1'b0;
            p_q        <= '0;
            r_q        <= '0;
        end else begin
            if (capture) begin
                cnt        <= CNT_INIT;
                rm_q       <= rm;
                rs_q       <= rs;
                acc_lo_q   <= acc_lo;
                acc_hi_q   <= acc_hi;
                rd_lo_q    <= rd_lo;
                rd_hi_q    <= rd_hi;
                long_q     <= long_op;
                acc_q      <= acc;
                signed_q   <= signed_op;
                setflags_q <= setflags;
            end else if (state == S_MUL && !abort && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end

            if (state == S_MUL && !abort && cnt == 3'd0) begin
                p_q <= mul_out;
            end

            if (state == S_ADD && !abort) begin
                r_q <= acc_q ? p_q + {(long_q ? acc_hi_q : 32'd0), acc_lo_q} : p_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed and random operations against a
// cycle-timeline reference model, plus abort, reset and back-to-back scenarios.
module tb_mul_sequencer;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] rm, rs, acc_lo, acc_hi;
        logic [3:0]  rd_lo, rd_hi;
        logic        long_op, acc, sgn, setflags;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, long_op, acc, signed_op, setflags, abort;
    logic [31:0] rm, rs, acc_lo, acc_hi;
    logic [3:0]  rd_lo, rd_hi;
    logic [31:0] mul_ina, mul_inb;
    logic        mul_sign;
    logic [63:0] mul_out;
    logic        busy, wr_en, flag_we, flag_n, flag_z, done;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    mul_sequencer #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .long_op(long_op), .acc(acc),
        .signed_op(signed_op), .setflags(setflags), .rm(rm), .rs(rs),
        .acc_lo(acc_lo), .acc_hi(acc_hi), .rd_lo(rd_lo), .rd_hi(rd_hi), .abort(abort),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_sign(mul_sign), .mul_out(mul_out),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z), .done(done)
    );

    always #5 clk = ~clk;

    // Combinational 32x32 multiplier the sequencer drives.
    always_comb begin
        if (mul_sign)
            mul_out = 64'($signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb}));
        else
            mul_out = {32'h0, mul_ina} * {32'h0, mul_inb};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk_op(logic [31:0] a, logic [31:0] b, logic [31:0] alo, logic [31:0] ahi,
                                  logic [3:0] dlo, logic [3:0] dhi,
                                  logic lg, logic ac, logic sg, logic sf);
        op_t o;
        o.rm = a; o.rs = b; o.acc_lo = alo; o.acc_hi = ahi;
        o.rd_lo = dlo; o.rd_hi = dhi;
        o.long_op = lg; o.acc = ac; o.sgn = sg; o.setflags = sf;
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rand_op();
        return mk_op(rand_word(), rand_word(), rand_word(), rand_word(),
                     4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom));
    endfunction

    // Architectural result: 64-bit product (signed only for signed long ops) plus accumulator, mod 2^64.
    function automatic logic [63:0] ref_r(op_t o);
        longint unsigned p, a;
        if (o.long_op && o.sgn)
            p = longint'($signed(o.rm)) * longint'($signed(o.rs));
        else
            p = longint'({32'h0, o.rm}) * longint'({32'h0, o.rs});
        a = o.acc ? {(o.long_op ? o.acc_hi : 32'h0), o.acc_lo} : 64'h0;
        return p + a;
    endfunction

    task automatic drive_op(input op_t o);
        rm = o.rm; rs = o.rs; acc_lo = o.acc_lo; acc_hi = o.acc_hi;
        rd_lo = o.rd_lo; rd_hi = o.rd_hi;
        long_op = o.long_op; acc = o.acc; signed_op = o.sgn; setflags = o.setflags;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy,     0);
        check({tag, "_wr_en"},   wr_en,    0);
        check({tag, "_done"},    done,     0);
        check({tag, "_flag_we"}, flag_we,  0);
        check({tag, "_flag_nz"}, {flag_n, flag_z}, 0);
        check({tag, "_wr_addr"}, wr_addr,  0);
        check({tag, "_wr_data"}, wr_data,  0);
        check({tag, "_mul_in"},  {mul_ina, mul_inb}, 0);
        check({tag, "_mul_sign"}, mul_sign, 0);
    endtask

    // One full operation from the IDLE state; operands are scrambled after capture and
    // a stray START is pulsed mid-operation, neither of which may affect the result.
    task automatic run_op(input op_t o);
        logic [63:0] r;
        int          fin;
        r   = ref_r(o);
        fin = LAT + 1 + int'(o.long_op);
        drive_op(o);
        start = 1'b1;
        tick();
        for (int i = 0; i <= fin + 1; i++) begin
            check("busy", busy, 64'(i <= fin));
            check("wr_en", wr_en, 64'(i == LAT + 1 || (o.long_op && i == LAT + 2)));
            check("done", done, 64'(i == fin));
            check("flag_we", flag_we, 64'(i == fin && o.setflags));
            if (i < LAT) begin
                check("mul_ina", mul_ina, o.rm);
                check("mul_inb", mul_inb, o.rs);
                check("mul_sign", mul_sign, o.sgn & o.long_op);
            end
            if (i == LAT + 1) begin
                check("wr_addr_lo", wr_addr, o.rd_lo);
                check("wr_data_lo", wr_data, r[31:0]);
            end
            if (o.long_op && i == LAT + 2) begin
                check("wr_addr_hi", wr_addr, o.rd_hi);
                check("wr_data_hi", wr_data, r[63:32]);
            end
            if (i == fin && o.setflags) begin
                check("flag_n", flag_n, o.long_op ? r[63] : r[31]);
                check("flag_z", flag_z, o.long_op ? 64'(r == 64'h0) : 64'(r[31:0] == 32'h0));
            end
            start = (i == 1);
            drive_op(rand_op());
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        op_t         a, b;
        logic [63:0] ra, rb;
        int          first_w, second_w, gap;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        drive_op(mk_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // Directed operations.
        run_op(mk_op(32'd7, 32'd6, 0, 0, 4'd3, 4'd0, 0, 0, 0, 0));
        run_op(mk_op(32'hFFFF_FFFF, 32'd1, 32'd1, 32'hDEAD_0000, 4'd2, 4'd9, 0, 1, 0, 1));
        run_op(mk_op(32'hFFFF_FFFE, 32'd3, 0, 0, 4'd1, 4'd2, 1, 0, 1, 1));
        run_op(mk_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd4, 4'd5, 1, 1, 0, 1));
        run_op(mk_op(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 4'd7, 1, 1, 1, 1));
        run_op(mk_op(32'd0, 32'h1234_5678, 0, 0, 4'd8, 4'd9, 1, 0, 1, 1));
        run_op(mk_op(32'h0001_0000, 32'h0001_0000, 0, 0, 4'd10, 4'd0, 0, 0, 0, 1));
        run_op(mk_op(32'hFFFF_FFFE, 32'd3, 0, 0, 4'd11, 4'd12, 0, 0, 1, 1));

        for (int n = 0; n < 24; n++) run_op(rand_op());

        // ABORT together with START in IDLE: nothing is captured.
        a = mk_op(32'h1111_1111, 32'h2222_2222, 0, 0, 4'd1, 4'd2, 0, 0, 0, 0);
        run_op(a);
        drive_op(mk_op(32'hAAAA_5555, 32'h5555_AAAA, 0, 0, 4'd3, 4'd4, 1, 0, 1, 1));
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_nocap", {mul_ina, mul_inb}, {a.rm, a.rs});

        // ABORT in the second MUL cycle.
        b = mk_op(32'h0BAD_F00D, 32'd5, 0, 0, 4'd6, 4'd7, 1, 0, 0, 1);
        drive_op(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        check("abort_mul_busy", busy, 1);
        check("abort_mul_strobes", {wr_en, done, flag_we}, 0);
        tick();
        abort = 1'b0;
        check("abort_mul_idle", busy, 0);
        check("abort_mul_keep", mul_ina, b.rm);
        for (int i = 0; i < 3; i++) begin
            check("abort_mul_quiet", {wr_en, done, flag_we}, 0);
            if (i < 2) tick();
        end
        run_op(mk_op(32'd100, 32'd200, 32'd5, 0, 4'd13, 4'd0, 0, 1, 0, 1));

        // ABORT in the final writeback cycle suppresses the strobes.
        drive_op(mk_op(32'd0, 32'd9, 0, 0, 4'd14, 4'd0, 0, 0, 0, 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (LAT + 1) tick();
        check("abort_wb_pre", {wr_en, done, flag_we}, 3'b111);
        abort = 1'b1;
        #1;
        check("abort_wb_strobes", {wr_en, done, flag_we}, 0);
        tick();
        abort = 1'b0;
        check("abort_wb_idle", busy, 0);

        // Reset asserted during WB_LO.
        drive_op(mk_op(32'd3, 32'd3, 0, 0, 4'd5, 4'd0, 0, 0, 0, 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (LAT + 1) tick();
        check("rst_mid_wr_en_pre", wr_en, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        #1;
        rst_n = 1'b1;
        tick();
        check_all_zero("rst_after");

        // Back-to-back with START held high.
        a  = mk_op(32'd12, 32'd13, 0, 0, 4'd1, 4'd0, 0, 0, 0, 0);
        b  = mk_op(32'hFFFF_0001, 32'h0000_0300, 32'd77, 0, 4'd2, 4'd0, 0, 1, 0, 0);
        ra = ref_r(a);
        rb = ref_r(b);
        first_w = -1; second_w = -1; gap = 0;
        drive_op(a);
        start = 1'b1;
        tick();
        drive_op(b);
        for (int i = 0; i < 3 * LAT + 10; i++) begin
            if (wr_en) begin
                if (first_w < 0) begin
                    first_w = i;
                    check("b2b_data_a", wr_data, ra[31:0]);
                end else if (second_w < 0) begin
                    second_w = i;
                    check("b2b_data_b", wr_data, rb[31:0]);
                end
            end
            if (!busy && i <= 2 * LAT + 3) gap++;
            if (i == LAT + 2) begin
                start = 1'b0;
                drive_op(rand_op());
            end
            tick();
        end
        check("b2b_first_write", 64'(first_w), 64'(LAT + 1));
        check("b2b_second_write", 64'(second_w), 64'(2 * LAT + 3));
        check("b2b_spacing", 64'(second_w - first_w), 64'(LAT + 2));
        check("b2b_busy_gap", 64'(gap), 0);
        check("b2b_end_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
